// File: rtl/i2s_tx_pkg.sv
// Shared audio-path definitions: word widths, divider ratios and the
// frame-load source selection used by the I2S transmitter.
package i2s_tx_pkg;

  // Bits per channel and sclk slots per stereo frame.
  localparam int DATA_W      = 16;
  localparam int FRAME_SLOTS = 32;

  // Audio clock divider ratios, as half-period counts of main_clk.
  localparam int MCLK_DIV  = 18;
  localparam int SCLK_DIV  = 36;
  localparam int LRCLK_DIV = 1152;

  // Word-select level for the left channel.
  localparam logic LR_LEFT = 1'b0;

  // Source of the word loaded into the shift register at a frame boundary.
  typedef enum logic [1:0] {
    LOAD_ZERO   = 2'd0,  // muted frame
    LOAD_HOLD   = 2'd1,  // buffered pair
    LOAD_BYPASS = 2'd2,  // pair presented on the boundary cycle itself
    LOAD_REPEAT = 2'd3   // nothing available: resend the last buffered pair
  } load_src_e;

  // Priority: mute, then the holding buffer, then a same-cycle bypass.
  // When none of these apply the frame repeats the last pair.
  function automatic load_src_e pick_load_src(input logic mute,
                                              input logic hold_full,
                                              input logic valid);
    if (mute)           return LOAD_ZERO;
    else if (hold_full) return LOAD_HOLD;
    else if (valid)     return LOAD_BYPASS;
    return LOAD_REPEAT;
  endfunction

endpackage

// File: rtl/i2s_tx_edge_det.sv
// Single-signal edge detector: registers the previous level of a
// main_clk-domain signal and flags rising/falling transitions.
module i2s_tx_edge_det #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic main_clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // Previous-cycle level of the watched signal.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the values that existed before the clock edge.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) level_q <= RESET_LEVEL;
    else        level_q <= level;
  end

  assign rise = level  & ~level_q;
  assign fall = level_q & ~level;

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips format) serial transmitter. Buffers one stereo pair behind
// a valid/ready handshake and shifts frames out MSB-first on sdata, one
// main_clk after each sclk falling edge. A frame starts on the sclk fall
// that coincides with lrclk going to the left channel; the one-slot I2S
// delay falls out naturally because that same edge still emits the
// previous frame's right-channel LSB.
module i2s_tx #(
  parameter int DATA_W = 16
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              mute,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  import i2s_tx_pkg::*;

  localparam int WORD_W = 2 * DATA_W;

  logic              sclk_rise;
  logic              sclk_fall;
  logic              lr_prev;
  logic              lrclk_q;
  logic              frame_bound;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] load_word;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic              hold_full;
  logic              bypass;
  logic              accept;
  load_src_e         load_src;

  // sclk arrives as a registered level; its falling edge paces all shifting.
  i2s_tx_edge_det #(
    .RESET_LEVEL (1'b0)
  ) u_sclk_edge (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .level    (sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // Word select as seen on the previous sclk fall; resets to "right" so the
  // first left phase after reset is recognised as a frame boundary.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n)         lr_prev <= ~LR_LEFT;
    else if (sclk_fall) lr_prev <= lrclk;
  end

  // Per-cycle copy of lrclk, used only to check word-select stability.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) lrclk_q <= ~LR_LEFT;
    else        lrclk_q <= lrclk;
  end

  // A frame begins when an sclk fall sees word select move right -> left.
  assign frame_bound = sclk_fall && (lr_prev != LR_LEFT) && (lrclk == LR_LEFT);

  assign load_src = pick_load_src(mute, hold_full, sample_valid);

  // A pair offered on the boundary cycle with an empty buffer goes straight
  // into the shift register and never occupies the holding buffer.
  assign bypass       = frame_bound && (load_src == LOAD_BYPASS);
  assign sample_ready = ~hold_full;
  assign accept       = sample_valid && sample_ready && !bypass;

  // Word presented to the shift register at a frame boundary.
  // NOTE: every always_comb output gets a default first, so no branch can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_word = '0;
    unique case (load_src)
      LOAD_ZERO:   load_word = '0;
      LOAD_HOLD:   load_word = {hold_l, hold_r};
      LOAD_BYPASS: load_word = {sample_left, sample_right};
      LOAD_REPEAT: load_word = {hold_l, hold_r};
      default:     load_word = '0;
    endcase
  end

  // Serializer: emit the current MSB on every sclk fall, then either shift
  // or, on a frame boundary, reload with the new frame word.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata <= 1'b0;
      shift <= '0;
    end else if (sclk_fall) begin
      sdata <= shift[WORD_W-1];
      if (frame_bound) shift <= load_word;
      else             shift <= {shift[WORD_W-2:0], 1'b0};
    end
  end

  // Holding buffer: a frame load drains it (muted or not), otherwise an
  // accepted handshake fills it. The two cannot coincide because a full
  // buffer deasserts ready.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
    end else if (frame_bound && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_l    <= sample_left;
      hold_r    <= sample_right;
      hold_full <= 1'b1;
    end
  end

  // Status pulses, one main_clk wide, aligned with the frame load.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_bound;
      underrun    <= frame_bound && (load_src == LOAD_REPEAT);
    end
  end

  // The DAC samples on sclk rising edges, so word select must never move there.
  a_ws_stable_on_rise: assert property (
    @(posedge main_clk) disable iff (!rst_n) sclk_rise |-> (lrclk == lrclk_q)
  );

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: models the audio clock divider, drives a table of
// per-frame stimulus records, and compares each serialised frame against a
// scoreboard queue of expected frame words and underrun flags.
module tb_i2s_tx;
  import i2s_tx_pkg::*;

  localparam int SLOT_CYC    = 2 * SCLK_DIV;
  localparam int FRAME_CYC   = 2 * LRCLK_DIV;
  localparam int PUSH_PHASE  = 1800;
  localparam int RESET_PHASE = 9 * SLOT_CYC + SCLK_DIV;
  localparam int N_VECS      = 13;

  typedef enum int { M_NONE, M_PUSH, M_BYPASS } mode_e;

  typedef struct {
    mode_e       mode;
    logic        mute;
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_word;
    logic        exp_under;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        under;
  } exp_t;

  logic              main_clk = 1'b0;
  logic              rst_n;
  logic              sclk;
  logic              lrclk;
  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              sample_valid;
  logic              sample_ready;
  logic              mute;
  logic              sdata;
  logic              frame_start;
  logic              underrun;

  int   div_p;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[N_VECS];

  logic [31:0] cur_word;
  logic        cur_under;
  logic        pend_under;
  logic        have_cur;
  logic        have_prev;

  i2s_tx #(.DATA_W(DATA_W)) dut (
    .main_clk     (main_clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 main_clk = ~main_clk;

  // Divider model: frame phase counter, reset into the right-channel half.
  always @(posedge main_clk or negedge rst_n) begin
    if (!rst_n)                   div_p <= LRCLK_DIV;
    else if (div_p == FRAME_CYC-1) div_p <= 0;
    else                          div_p <= div_p + 1;
  end
  assign sclk  = (div_p % SLOT_CYC) >= SCLK_DIV;
  assign lrclk = (div_p >= LRCLK_DIV);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_p(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < FRAME_CYC + 100; i++) begin
      @(negedge main_clk);
      if (div_p == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_phase: phase %0d not reached", target);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit got = 1'b0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (sample_ready) begin
        @(negedge main_clk);
        got = 1'b1;
        break;
      end
      @(negedge main_clk);
    end
    sample_valid = 1'b0;
    check("push_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic expect_frame(input logic [31:0] word, input logic under);
    exp_t e;
    e.word  = word;
    e.under = under;
    sb.push_back(e);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    wait_p(PUSH_PHASE);
    check($sformatf("row%0d_ready_idle", idx), {31'd0, sample_ready}, 32'd1);
    mute = v.mute;
    expect_frame(v.exp_word, v.exp_under);
    case (v.mode)
      M_PUSH: begin
        push_pair(v.l, v.r);
        check($sformatf("row%0d_ready_full", idx), {31'd0, sample_ready}, 32'd0);
      end
      M_BYPASS: begin
        wait_p(0);
        sample_left  = v.l;
        sample_right = v.r;
        sample_valid = 1'b1;
        check($sformatf("row%0d_bypass_ready_pre", idx), {31'd0, sample_ready}, 32'd1);
        @(negedge main_clk);
        sample_valid = 1'b0;
        check($sformatf("row%0d_bypass_ready_post", idx), {31'd0, sample_ready}, 32'd1);
      end
      default: ;
    endcase
  endtask

  // Frame monitor: rebuilds each frame from sdata sampled mid-slot (sclk
  // high) and scores it once the next frame's slot 0 has been seen.
  always @(negedge main_clk) begin : monitor
    int   slot;
    exp_t e;
    if (!rst_n) begin
      have_cur  = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (frame_start) begin
        check("frame_align", div_p, 32'd1);
        pend_under = cur_under;
        cur_under  = underrun;
        have_prev  = have_cur;
        have_cur   = 1'b1;
      end
      if (have_cur && (div_p % SLOT_CYC) == SCLK_DIV) begin
        slot = div_p / SLOT_CYC;
        if (slot == 0) begin
          if (!have_prev) begin
            check("first_slot0", {31'd0, sdata}, 32'd0);
          end else if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: frame completed with no expectation queued");
          end else begin
            e = sb.pop_front();
            check("frame_word", {cur_word[31:1], sdata}, e.word);
            check("frame_underrun", {31'd0, pend_under}, {31'd0, e.under});
          end
        end else begin
          cur_word[32-slot] = sdata;
        end
      end
    end
  end

  initial begin
    bit drained;
    cur_word   = '0;
    cur_under  = 1'b0;
    pend_under = 1'b0;

    vecs[0]  = '{M_PUSH,   1'b0, 16'hA5C3, 16'h0F01, 32'hA5C30F01, 1'b0};
    for (int k = 1; k <= 4; k++)
      vecs[k] = '{M_PUSH, 1'b0, 16'(k), 16'(k + 256), {16'(k), 16'(k + 256)}, 1'b0};
    vecs[5]  = '{M_PUSH,   1'b0, 16'h1234, 16'h5678, 32'h12345678, 1'b0};
    vecs[6]  = '{M_NONE,   1'b0, 16'h0000, 16'h0000, 32'h12345678, 1'b1};
    vecs[7]  = '{M_NONE,   1'b0, 16'h0000, 16'h0000, 32'h12345678, 1'b1};
    vecs[8]  = '{M_BYPASS, 1'b0, 16'h7FFF, 16'h8000, 32'h7FFF8000, 1'b0};
    vecs[9]  = '{M_PUSH,   1'b1, 16'hFFFF, 16'hFFFF, 32'h00000000, 1'b0};
    vecs[10] = '{M_PUSH,   1'b0, 16'h80FF, 16'h7FFE, 32'h80FF7FFE, 1'b0};
    vecs[11] = '{M_NONE,   1'b1, 16'h0000, 16'h0000, 32'h00000000, 1'b0};
    vecs[12] = '{M_NONE,   1'b0, 16'h0000, 16'h0000, 32'h80FF7FFE, 1'b1};

    rst_n        = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    sample_valid = 1'b0;
    mute         = 1'b0;
    repeat (5) @(negedge main_clk);
    check("reset_sdata",       {31'd0, sdata},       32'd0);
    check("reset_ready",       {31'd0, sample_ready}, 32'd1);
    check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    check("reset_underrun",    {31'd0, underrun},    32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < N_VECS; i++) run_row(i, vecs[i]);

    // Mid-frame reset: refill the buffer, then reset during slot 9 of a
    // frame that is driving a 1 on sdata.
    wait_p(PUSH_PHASE);
    wait_p(400);
    push_pair(16'h1111, 16'h2222);
    check("rst_pre_ready", {31'd0, sample_ready}, 32'd0);
    wait_p(RESET_PHASE);
    check("rst_pre_sdata", {31'd0, sdata}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sdata",       {31'd0, sdata},        32'd0);
    check("rst_mid_ready",       {31'd0, sample_ready}, 32'd1);
    check("rst_mid_frame_start", {31'd0, frame_start},  32'd0);
    sb.delete();
    repeat (10) @(negedge main_clk);
    rst_n = 1'b1;
    expect_frame(32'hBEEFCAFE, 1'b0);
    push_pair(16'hBEEF, 16'hCAFE);
    check("rst_post_ready_full", {31'd0, sample_ready}, 32'd0);

    drained = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge main_clk);
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("sb_drained", {31'd0, drained}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S serial transmitter for the audio DAC output path.
- Sits directly downstream of the audio clock divider and runs on `main_clk`.
- Inputs from the divider: `lrclk` (main/2304, 43.4 kHz) and `sclk` (main/72, 1.39 MHz), both registered in the `main_clk` domain, giving 32 sclk periods per frame.
- Accepts stereo samples over a valid/ready handshake, buffers one frame, and shifts them out MSB-first in Philips I2S format on `sdata`.

Parameters:
- DATA_W, 16, bits per channel; a frame uses 2*DATA_W sclk slots.

Ports:
- main_clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; asynchronous assert, active-low.
- sclk  in  1  serial bit clock from the divider (main_clk-domain level).
- lrclk  in  1  word-select from the divider; 0 = left, 1 = right.
- sample_left  in  DATA_W  left sample, two's complement.
- sample_right  in  DATA_W  right sample.
- sample_valid  in  1  producer has a stereo pair.
- sample_ready  out  1  holding buffer empty; a pair is accepted when valid&ready.
- mute  in  1  when 1, frames load zeros instead of buffered data.
- sdata  out  1  serial data to the DAC.
- frame_start  out  1  one-cycle pulse on each left-frame load.
- underrun  out  1  one-cycle pulse when a frame loads with the buffer empty.

Behaviour:
- Reset (rst_n=0, async):
  - sdata=0, shift=0, hold_l=hold_r=0, hold_full=0.
  - sclk_q=0, lr_prev=1 (matches divider reset state).
  - frame_start=0, underrun=0; sample_ready=1.
- Clocking and edge detection:
  - All state updates on posedge main_clk.
  - sclk falling edge (sfe) = sclk_q & ~sclk, with sclk_q registered every cycle.
  - Every action below happens only on the cycle where sfe=1, so sdata changes exactly 1 main_clk after sclk falls. The DAC samples on the sclk rising edge.
- Frame boundary:
  - Asserted on an sfe cycle with lr_prev=1 and lrclk=0.
  - lr_prev updates to lrclk on every sfe cycle.
  - The divider aligns each lrclk toggle with a sclk falling edge.
- On an sfe that is not a frame boundary:
  - sdata <= shift[2*DATA_W-1]
  - shift <= shift << 1
- On a frame boundary:
  - sdata <= shift[2*DATA_W-1]. This is the previous right LSB, giving the I2S one-slot delay.
  - shift <= load word, selected in this priority order:
    - mute=1: zeros.
    - hold_full=1: {hold_l, hold_r}; then hold_full <= 0.
    - hold_full=0 and sample_valid=1 (bypass, same cycle): {sample_left, sample_right}; the sample is consumed and hold_full stays 0.
    - otherwise: {hold_l, hold_r}, i.e. the last sample is repeated; underrun=1 for this cycle.
  - frame_start=1 for this cycle.
  - When mute=1, the buffered pair is still consumed (hold_full <= 0), so the producer does not stall.
- Resulting slot map:
  - Slot 0 after the lrclk fall carries the previous right[0].
  - Slots 1..16 carry left[15:0].
  - Slots 17..31 carry right[15:1].
- Handshake:
  - sample_ready = ~hold_full (combinational).
  - On valid & ready, outside a bypass load: hold_l/hold_r <= inputs and hold_full <= 1.
  - Data is not accepted while full. The producer holds inputs stable until accepted.
- Simultaneous events:
  - A frame load with a hold_full pair plus valid in the same cycle: ready was 0, so the new pair is not taken that cycle.
  - A push with no frame boundary is an ordinary fill.
- Missing frames: lrclk edges with no sclk fall are ignored, and no frame loads.
- Reset mid-frame: everything clears and sdata=0. The first boundary after reset outputs 0 in slot 0.
- No latency to sdata other than the 1-cycle sfe detection; a sample appears at the first left frame after acceptance.

Decomposition:
- Shared audio package holds:
  - DATA_W = 16
  - FRAME_SLOTS = 32
  - divider ratios: MCLK_DIV = 18, SCLK_DIV = 36, LRCLK_DIV = 1152 (half-period counts)
  - LR_LEFT = 1'b0
- One natural sub-module: edge_det. It is instantiated for sclk and registers the previous level, producing rise/fall pulses; reset level is a parameter.

Test Plan:
- Basic frame: drive the real divider; push L=16'hA5C3, R=16'h0F01 before the first lrclk fall. Sample sdata on sclk rises. Expect slots 1..16 = 1010010111000011, slots 17..31 = 000011110000000, and slot 0 of the next frame = 1.
- Back-to-back: push a new pair every frame (ramp 0x0001, 0x0002, ...). Expect each frame to carry the next value, underrun never asserted, and exactly one frame_start per 2304 main_clk.
- Underrun: push one pair (0x1234, 0x5678), then stop. Expect the second frame to repeat 0x1234/0x5678 and underrun to pulse once per frame thereafter.
- Bypass: keep the buffer empty and assert valid with 0x7FFF/0x8000 exactly on the frame-boundary cycle. Expect sample_ready to stay 1, no underrun, and that frame to carry 0x7FFF/0x8000.
- Mute: set mute=1 with the buffer full (0xFFFF/0xFFFF). Expect all slots of that frame = 0, the buffer consumed (sample_ready returns to 1), and no underrun.
- Reset mid-frame: deassert rst_n at slot 9. Expect sdata=0 immediately and sample_ready=1. After release, the first frame_start occurs at the next lrclk fall, and that frame carries the first sample pushed after reset.
